mac_accumulator: RTL and testbench
==================================

// Module: mac_accumulator
// PURPOSE
//  Signed accumulate stage directly downstream of the radix-8 Booth multiplier.
//  Consumes a stream of signed products (IN_SIZE_0+IN_SIZE_1 bits) over a valid/ready
//  handshake and sums a programmed number of them into a wide accumulator.
//  Presents the dot-product result on a registered valid/ready output port.
// PARAMETERS
//  IN_SIZE_0  4   multiplicand width of upstream multiplier
//  IN_SIZE_1  8   multiplier width of upstream multiplier
//  ACC_SIZE   16  accumulator/result width; must be >= IN_SIZE_0+IN_SIZE_1
//  LEN_W      8   width of term-count input
// PORTS
//  clk_i        in   1                   clock, rising edge
//  rst_ni       in   1                   async reset, active low
//  start_i      in   1                   begin new accumulation (sampled in IDLE only)
//  len_i        in   LEN_W               number of products to accumulate
//  prod_i       in   IN_SIZE_0+IN_SIZE_1 signed product from multiplier
//  prod_valid_i in   1                   prod_i valid
//  prod_ready_o out  1                   block accepts prod_i
//  res_data_o   out  ACC_SIZE            signed accumulated result
//  res_valid_o  out  1                   result valid
//  res_ready_i  in   1                   downstream accepts result
//  busy_o       out  1                   state != IDLE
//  ovf_o        out  1                   signed overflow seen in current job
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE; acc, cnt, res_data_o=0; res_valid_o=0,
//   prod_ready_o=0, busy_o=0, ovf_o=0. Applies immediately, also mid-job; partial sum discarded.
//  FSM IDLE -> ACC -> DONE -> IDLE. All outputs decode from registered state/acc.
//  IDLE: prod_ready_o=0. start_i=1: acc<=0, ovf<=0, cnt<=len_i;
//   len_i!=0 -> ACC; len_i==0 -> DONE (result 0 valid next cycle).
//  ACC: prod_ready_o=1. Beat = prod_valid_i & prod_ready_o. Per beat:
//   acc <= acc + sext(prod_i) to ACC_SIZE; cnt <= cnt-1. Cycles without beat: no change.
//   Beat with cnt==1 -> DONE; res_valid_o rises the cycle after the last beat.
//  DONE: res_valid_o=1, res_data_o=acc held stable while res_ready_i=0.
//   res_valid_o & res_ready_i -> IDLE next cycle; res_valid_o drops.
//  start_i ignored outside IDLE; no new job until result is taken (>=1 IDLE cycle between jobs).
//  Overflow: sum computed at ACC_SIZE+1 bits; signed overflow if result outside
//   [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1]; ovf_o set, sticky until next accepted start_i.
//  ovf_o valid throughout ACC and DONE; cleared on accepted start_i.
//  len_i full scale (2^LEN_W-1) supported; cnt never wraps.
// CONFIGURATION
//  MAC_SATURATE_EN defined: each addition clamps to 2^(ACC_SIZE-1)-1 / -2^(ACC_SIZE-1);
//   later beats may move acc back off the rail; ovf_o still set on any clamp.
//  MAC_SATURATE_EN undefined: two's-complement wrap modulo 2^ACC_SIZE; ovf_o flags wrap.
// TESTING (IN_SIZE_0=4, IN_SIZE_1=8, ACC_SIZE=16, LEN_W=8)
//  start len=3, prods 10,-4,7 back-to-back -> res_data_o=0x000D one cycle after 3rd beat, ovf_o=0.
//  start len=0 -> DONE next cycle, res_data_o=0x0000, res_valid_o=1, no prod beat accepted.
//  len=2, prod_valid_i gaps of 3 cycles -> only 2 beats counted, result = sum of those two.
//  DONE with res_ready_i=0 for 5 cycles, start_i pulsed -> data stable, prod_ready_o=0,
//   start ignored, busy_o=1.
//  len=20, prod=+2047 each -> no macro: 0x9FEC, ovf_o=1; MAC_SATURATE_EN: 0x7FFF, ovf_o=1.
//  rst_ni low after 2 beats of len=4 job -> all outputs 0 at once;
//   then len=1, prod=-1 -> 0xFFFF.

Source files
------------

// File: rtl/mac_accumulator.sv
// Signed product accumulator with valid/ready input and registered result port.
// Optional clamping of each addition is enabled by defining MAC_SATURATE_EN.
module mac_accumulator #(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int ACC_SIZE  = 16,
    parameter int LEN_W     = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [LEN_W-1:0]               len_i,
    input  logic [IN_SIZE_0+IN_SIZE_1-1:0] prod_i,
    input  logic                           prod_valid_i,
    output logic                           prod_ready_o,
    output logic [ACC_SIZE-1:0]            res_data_o,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic                           busy_o,
    output logic                           ovf_o
);

    localparam int PW = IN_SIZE_0 + IN_SIZE_1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [ACC_SIZE-1:0] r_acc;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_ovf;

    logic                w_beat;
    logic [ACC_SIZE:0]   w_sum;
    logic                w_ovf;
    logic [ACC_SIZE-1:0] w_next;

    assign prod_ready_o = (r_state == S_ACC);
    assign res_valid_o  = (r_state == S_DONE);
    assign busy_o       = (r_state != S_IDLE);
    assign res_data_o   = r_acc;
    assign ovf_o        = r_ovf;

    assign w_beat = prod_valid_i & prod_ready_o;

    // One guard bit: overflow shows up as disagreement of the top two bits.
    always_comb begin
        w_sum = {r_acc[ACC_SIZE-1], r_acc}
              + {{(ACC_SIZE + 1 - PW){prod_i[PW-1]}}, prod_i};
        w_ovf = w_sum[ACC_SIZE] ^ w_sum[ACC_SIZE-1];
`ifdef MAC_SATURATE_EN
        if (w_ovf) begin
            w_next = w_sum[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                                     : {1'b0, {(ACC_SIZE-1){1'b1}}};
        end else begin
            w_next = w_sum[ACC_SIZE-1:0];
        end
`else
        w_next = w_sum[ACC_SIZE-1:0];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= len_i;
                        r_state <= (len_i == '0) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_beat) begin
                        r_acc <= w_next;
                        r_cnt <= r_cnt - 1'b1;
                        if (w_ovf) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized self-checking bench for mac_accumulator.
// Expected sums come from an integer model of the accumulate rules.
module tb_mac_accumulator;

    localparam int I0 = 4;
    localparam int I1 = 8;
    localparam int AW = 16;
    localparam int LW = 8;
    localparam int PW = I0 + I1;
    localparam int AMAX = 32767;
    localparam int AMIN = -32768;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic [PW-1:0] prod_i = '0;
    logic          prod_valid_i = 1'b0;
    logic          prod_ready_o;
    logic [AW-1:0] res_data_o;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic          busy_o;
    logic          ovf_o;

    int total = 0;
    int bad = 0;
    int m_acc;
    bit m_ovf;

    always #5 clk = ~clk;

    mac_accumulator #(
        .IN_SIZE_0(I0), .IN_SIZE_1(I1), .ACC_SIZE(AW), .LEN_W(LW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .len_i(len_i),
        .prod_i(prod_i), .prod_valid_i(prod_valid_i),
        .prod_ready_o(prod_ready_o), .res_data_o(res_data_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .ovf_o(ovf_o)
    );

    // Reference: exact integer sum, then wrap or clamp to the result range.
    function automatic void m_add(input int p);
        int s;
        logic [AW-1:0] t;
        s = m_acc + p;
        if (s > AMAX || s < AMIN) m_ovf = 1'b1;
`ifdef MAC_SATURATE_EN
        if (s > AMAX) s = AMAX;
        if (s < AMIN) s = AMIN;
        m_acc = s;
`else
        t = s[AW-1:0];
        m_acc = int'($signed(t));
`endif
    endfunction

    task automatic do_start(input int len);
        start_i = 1'b1;
        len_i = LW'(len);
        m_acc = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_prod(input logic [PW-1:0] p);
        int n = 0;
        while (!prod_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!prod_ready_o) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: prod_ready_o=%0b required 1", prod_ready_o);
        end
        prod_i = p;
        prod_valid_i = 1'b1;
        m_add(int'($signed(p)));
        @(negedge clk);
        prod_valid_i = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!res_valid_o) begin
            bad++;
            $display("FAIL res_timeout: res_valid_o=%0b required 1", res_valid_o);
        end
    endtask

    task automatic take_res();
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        total++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL take: valid=%0b busy=%0b required 0 0", res_valid_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({res_data_o, res_valid_o, prod_ready_o, busy_o, ovf_o} !== '0) begin
            bad++;
            $display("FAIL reset: data=%h v=%b r=%b b=%b o=%b required all 0",
                     res_data_o, res_valid_o, prod_ready_o, busy_o, ovf_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_start(3);
        total++;
        if (busy_o !== 1'b1 || prod_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL basic_acc: busy=%b ready=%b required 1 1", busy_o, prod_ready_o);
        end
        send_prod(12'sd10);
        send_prod(-12'sd4);
        send_prod(12'sd7);
        total++;
        if (res_valid_o !== 1'b1 || res_data_o !== 16'h000D || ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL basic: v=%b data=%h ovf=%b required 1 000d 0",
                     res_valid_o, res_data_o, ovf_o);
        end
        take_res();
    endtask

    task automatic test_len0();
        prod_valid_i = 1'b1;
        prod_i = 12'd5;
        do_start(0);
        total++;
        if (res_valid_o !== 1'b1 || res_data_o !== '0 || prod_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL len0: v=%b data=%h ready=%b required 1 0000 0",
                     res_valid_o, res_data_o, prod_ready_o);
        end
        take_res();
        prod_valid_i = 1'b0;
        total++;
        if (res_data_o !== '0) begin
            bad++;
            $display("FAIL len0_nobeat: data=%h required 0000", res_data_o);
        end
    endtask

    task automatic test_gaps();
        logic [PW-1:0] p;
        do_start(2);
        p = PW'($urandom);
        send_prod(p);
        repeat (3) @(negedge clk);
        total++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b1 || res_data_o !== AW'(m_acc)) begin
            bad++;
            $display("FAIL gaps_mid: v=%b busy=%b data=%h required 0 1 %h",
                     res_valid_o, busy_o, res_data_o, AW'(m_acc));
        end
        p = PW'($urandom);
        send_prod(p);
        total++;
        if (res_valid_o !== 1'b1 || res_data_o !== AW'(m_acc)) begin
            bad++;
            $display("FAIL gaps: v=%b data=%h required 1 %h",
                     res_valid_o, res_data_o, AW'(m_acc));
        end
        take_res();
    endtask

    task automatic test_done_hold();
        do_start(1);
        send_prod(-12'sd300);
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            len_i = 8'd5;
            @(negedge clk);
            start_i = 1'b0;
            total++;
            if (res_valid_o !== 1'b1 || res_data_o !== AW'(m_acc) ||
                prod_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL done_hold%0d: v=%b data=%h r=%b b=%b required 1 %h 0 1",
                         i, res_valid_o, res_data_o, prod_ready_o, busy_o, AW'(m_acc));
            end
        end
        take_res();
    endtask

    task automatic test_overflow();
        do_start(20);
        repeat (20) send_prod(12'sd2047);
        total++;
        if (res_valid_o !== 1'b1 || res_data_o !== AW'(m_acc) || ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL overflow: v=%b data=%h ovf=%b required 1 %h 1",
                     res_valid_o, res_data_o, ovf_o, AW'(m_acc));
        end
        take_res();
        do_start(1);
        total++;
        if (ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: ovf=%b required 0", ovf_o);
        end
        send_prod(12'sd1);
        take_res();
    endtask

    task automatic test_mid_reset();
        do_start(4);
        send_prod(12'sd100);
        send_prod(12'sd55);
        rst_n = 1'b0;
        #1;
        total++;
        if ({res_data_o, res_valid_o, prod_ready_o, busy_o, ovf_o} !== '0) begin
            bad++;
            $display("FAIL mid_reset: data=%h v=%b r=%b b=%b o=%b required all 0",
                     res_data_o, res_valid_o, prod_ready_o, busy_o, ovf_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(1);
        send_prod(-12'sd1);
        total++;
        if (res_valid_o !== 1'b1 || res_data_o !== 16'hFFFF) begin
            bad++;
            $display("FAIL post_reset: v=%b data=%h required 1 ffff", res_valid_o, res_data_o);
        end
        take_res();
    endtask

    task automatic test_random();
        int len;
        for (int j = 0; j < 10; j++) begin
            len = (j == 9) ? 255 : int'($urandom_range(0, 8));
            do_start(len);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_prod(PW'($urandom));
            end
            wait_res();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            total++;
            if (res_data_o !== AW'(m_acc) || ovf_o !== m_ovf) begin
                bad++;
                $display("FAIL random%0d len=%0d: data=%h ovf=%b required %h %b",
                         j, len, res_data_o, ovf_o, AW'(m_acc), m_ovf);
            end
            take_res();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_len0();
        test_gaps();
        test_done_hold();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
